// File: rtl/aw_wr_arbiter.sv
// Round-robin AW/W grant arbiter for two write masters: holds the AW select until the
// address handshake, then the W select until the burst's last beat, flagging WLAST/length mismatches.
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 8
`endif

module aw_wr_arbiter #(
  parameter bit RST_PRIO = 1'b0
) (
  input  logic                     ACLK,
  input  logic                     ARESETn,
  input  logic                     AWVALID_M0,
  input  logic                     AWVALID_M1,
  input  logic                     AWVALID,
  input  logic                     AWREADY,
  input  logic [`AXI_LEN_BITS-1:0] AWLEN,
  input  logic                     WVALID,
  input  logic                     WREADY,
  input  logic                     WLAST,
  output logic [1:0]               gnt,
  output logic [1:0]               w_gnt,
  output logic                     busy,
  output logic                     wlast_err
);

  localparam int LW = `AXI_LEN_BITS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      gnt_d, w_gnt_d;
  logic            busy_d, err_d;
  logic [LW-1:0]   cnt_q, cnt_d;
  logic [LW-1:0]   len_q, len_d;
  logic            prio_q, prio_d;
  logic            winner;
  logic            beat;
  logic            at_len;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q   <= IDLE;
      gnt       <= 2'b00;
      w_gnt     <= 2'b00;
      busy      <= 1'b0;
      wlast_err <= 1'b0;
      cnt_q     <= '0;
      len_q     <= '0;
      prio_q    <= RST_PRIO;
    end else begin
      state_q   <= state_d;
      gnt       <= gnt_d;
      w_gnt     <= w_gnt_d;
      busy      <= busy_d;
      wlast_err <= err_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      prio_q    <= prio_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt;
    w_gnt_d = w_gnt;
    err_d   = 1'b0;
    cnt_d   = cnt_q;
    len_d   = len_q;
    prio_d  = prio_q;
    winner  = 1'b0;
    beat    = WVALID && WREADY;
    at_len  = (cnt_q == len_q);

    case (state_q)
      IDLE: begin
        gnt_d   = 2'b00;
        w_gnt_d = 2'b00;
        if (AWVALID_M0 || AWVALID_M1) begin
          // Pointer only breaks ties; after any grant it favours the loser.
          winner  = (AWVALID_M0 && AWVALID_M1) ? prio_q : AWVALID_M1;
          gnt_d   = winner ? 2'b10 : 2'b01;
          prio_d  = ~winner;
          state_d = ADDR;
        end
      end
      ADDR: begin
        if (AWVALID && AWREADY) begin
          len_d   = AWLEN;
          cnt_d   = '0;
          gnt_d   = 2'b00;
          w_gnt_d = gnt;
          state_d = DATA;
        end
      end
      DATA: begin
        gnt_d = 2'b00;
        if (beat) begin
          // Either an asserted WLAST or reaching the captured length closes the burst;
          // disagreement between the two is the error condition.
          if (WLAST || at_len) begin
            w_gnt_d = 2'b00;
            err_d   = WLAST ^ at_len;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + {{(LW-1){1'b0}}, 1'b1};
          end
        end
      end
      default: begin
        gnt_d   = 2'b00;
        w_gnt_d = 2'b00;
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

endmodule

// File: tb/tb_aw_wr_arbiter.sv
// Randomized scoreboard bench for aw_wr_arbiter: the driver plays both masters and the slave,
// predicting grants and burst outcomes; a negedge monitor pops and compares.
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 8
`endif

module tb_aw_wr_arbiter;

  localparam int LW       = `AXI_LEN_BITS;
  localparam bit RST_PRIO = 1'b0;

  logic          ACLK;
  logic          ARESETn;
  logic          AWVALID_M0, AWVALID_M1, AWVALID, AWREADY;
  logic [LW-1:0] AWLEN;
  logic          WVALID, WREADY, WLAST;
  logic [1:0]    gnt, w_gnt;
  logic          busy, wlast_err;

  aw_wr_arbiter #(.RST_PRIO(RST_PRIO)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWVALID_M0(AWVALID_M0), .AWVALID_M1(AWVALID_M1),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWLEN(AWLEN),
    .WVALID(WVALID), .WREADY(WREADY), .WLAST(WLAST),
    .gnt(gnt), .w_gnt(w_gnt), .busy(busy), .wlast_err(wlast_err)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  typedef struct { logic [1:0] code; int at_cyc; } gexp_t;
  typedef struct { int beats; bit err; } bexp_t;
  // mode: 0 = correct WLAST, 1 = early WLAST at beat pos, 2 = WLAST never asserted
  typedef struct {
    bit r0; bit r1; int len; int mode; int pos; int astall;
    bit other; bit wearly; bit ovl;
  } plan_t;

  gexp_t sb_grant[$];
  bexp_t sb_burst[$];
  plan_t plans[$];

  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  bit ptr;
  bit done = 1'b0;
  bit pre_raised = 1'b0;

  always @(posedge ACLK) cyc <= cyc + 1;

  function automatic plan_t mk(bit r0, bit r1, int len, int mode, int pos, int astall,
                               bit other, bit wearly, bit ovl);
    plan_t p;
    p.r0 = r0; p.r1 = r1; p.len = len; p.mode = mode; p.pos = pos;
    p.astall = astall; p.other = other; p.wearly = wearly; p.ovl = ovl;
    return p;
  endfunction

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  // Reference model: which master wins and how the burst must end, from the rules alone.
  task automatic raise(input plan_t p, input bit ovl);
    int w;
    gexp_t g;
    bexp_t b;
    w = (p.r0 && p.r1) ? int'(ptr) : (p.r1 ? 1 : 0);
    ptr = (w == 0);
    g.code   = (w == 1) ? 2'b10 : 2'b01;
    g.at_cyc = ovl ? cyc + 2 : cyc + 1;
    b.beats  = (p.mode == 1) ? p.pos + 1 : p.len + 1;
    b.err    = (p.mode != 0);
    sb_grant.push_back(g);
    sb_burst.push_back(b);
    AWVALID_M0 = p.r0;
    AWVALID_M1 = p.r1;
  endtask

  task automatic wait_grant();
    int t;
    t = 0;
    while (gnt == 2'b00) begin
      if (t > 40) begin
        $display("FAIL grant_timeout: gnt=%0d after %0d cycles, required nonzero", gnt, t);
        $fatal(1);
      end
      tick();
      t++;
    end
  endtask

  task automatic run_burst(input plan_t p, input bit has_nxt, input plan_t n);
    logic [1:0] code;
    int nb;
    if (!pre_raised) raise(p, 1'b0);
    pre_raised = 1'b0;
    wait_grant();
    code    = gnt;
    AWVALID = 1'b1;
    AWLEN   = LW'(p.len);
    if (p.other) begin
      if (code == 2'b01) AWVALID_M1 = 1'b1;
      else               AWVALID_M0 = 1'b1;
    end
    if (p.wearly) begin
      WVALID = 1'b1;
      WREADY = 1'($urandom_range(0, 1));
    end
    repeat (p.astall) tick();
    AWREADY = 1'b1;
    tick();
    AWVALID = 1'b0; AWREADY = 1'b0; AWVALID_M0 = 1'b0; AWVALID_M1 = 1'b0;
    WVALID = 1'b0; WREADY = 1'b0;
    nb = (p.mode == 1) ? p.pos + 1 : p.len + 1;
    for (int i = 0; i < nb; i++) begin
      repeat ($urandom_range(0, 2)) begin
        if ($urandom_range(0, 1) == 1) begin
          WVALID = 1'b0; WREADY = 1'($urandom_range(0, 1));
        end else begin
          WVALID = 1'b1; WREADY = 1'b0;
        end
        WLAST = 1'($urandom_range(0, 1));
        tick();
      end
      WVALID = 1'b1;
      WREADY = 1'b1;
      WLAST  = (p.mode == 0 && i == p.len) || (p.mode == 1 && i == p.pos);
      if (i == nb - 1 && has_nxt && n.ovl) begin
        raise(n, 1'b1);
        pre_raised = 1'b1;
      end
      tick();
    end
    WVALID = 1'b0; WREADY = 1'b0; WLAST = 1'b0;
    if (!(has_nxt && n.ovl)) repeat ($urandom_range(0, 2)) tick();
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: checks every cycle away from the active edge.
  logic [1:0] prev_g = 2'b00;
  logic [1:0] prev_w = 2'b00;
  int         beats = 0;

  always @(negedge ACLK) begin : monitor
    gexp_t g;
    bexp_t b;
    if (done) begin
      check("grant_queue_drained", sb_grant.size(), 0);
      check("burst_queue_drained", sb_burst.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
    end else if (!ARESETn) begin
      check("rst_gnt", int'(gnt), 0);
      check("rst_w_gnt", int'(w_gnt), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_wlast_err", int'(wlast_err), 0);
      prev_g = 2'b00;
      prev_w = 2'b00;
      beats  = 0;
    end else begin
      check("busy", int'(busy), int'((gnt != 2'b00) || (w_gnt != 2'b00)));
      check("aw_w_exclusive", int'((gnt != 2'b00) && (w_gnt != 2'b00)), 0);
      if (prev_g == 2'b00 && gnt != 2'b00) begin
        if (sb_grant.size() == 0) check("unexpected_grant", int'(gnt), 0);
        else begin
          g = sb_grant.pop_front();
          check("grant_master", int'(gnt), int'(g.code));
          check("grant_cycle", cyc, g.at_cyc);
        end
      end
      if (prev_g != 2'b00 && gnt != 2'b00) check("gnt_hold", int'(gnt), int'(prev_g));
      if (prev_g != 2'b00 && gnt == 2'b00) check("w_gnt_after_aw", int'(w_gnt), int'(prev_g));
      if (prev_w != 2'b00 && w_gnt != 2'b00) check("w_gnt_hold", int'(w_gnt), int'(prev_w));
      if (prev_w != 2'b00 && w_gnt == 2'b00) begin
        check("bubble_after_burst", int'(gnt), 0);
        if (sb_burst.size() == 0) check("unexpected_burst_end", 1, 0);
        else begin
          b = sb_burst.pop_front();
          check("burst_beats", beats, b.beats);
          check("wlast_err", int'(wlast_err), int'(b.err));
        end
        beats = 0;
      end else begin
        check("wlast_err_quiet", int'(wlast_err), 0);
      end
      if (w_gnt != 2'b00 && WVALID && WREADY) beats++;
      prev_g = gnt;
      prev_w = w_gnt;
    end
  end

  initial begin : driver
    plan_t q1, q2;
    int r, len, mode, pos;
    ARESETn = 1'b0;
    AWVALID_M0 = 1'b0; AWVALID_M1 = 1'b0; AWVALID = 1'b0; AWREADY = 1'b0;
    AWLEN = '0; WVALID = 1'b0; WREADY = 1'b0; WLAST = 1'b0;
    ptr = RST_PRIO;

    // Contention with back-to-back single beats, then the directed corner bursts.
    plans.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0));
    plans.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 1));
    plans.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 1));
    plans.push_back(mk(1, 0, 3, 0, 0, 2, 0, 0, 0));
    plans.push_back(mk(0, 1, 3, 1, 1, 1, 0, 0, 0));
    plans.push_back(mk(1, 0, 2, 2, 0, 0, 0, 0, 0));
    plans.push_back(mk(1, 0, 2, 0, 0, 5, 1, 1, 0));
    for (int i = 0; i < 120; i++) begin
      r    = int'($urandom_range(1, 3));
      len  = int'($urandom_range(0, 7));
      mode = int'($urandom_range(0, 2));
      if (len == 0 && mode == 1) mode = 0;
      pos  = (mode == 1) ? int'($urandom_range(0, len - 1)) : 0;
      plans.push_back(mk(r[0], r[1], len, mode, pos, int'($urandom_range(0, 3)),
                         ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                         ($urandom_range(0, 1) == 1)));
    end

    repeat (3) @(posedge ACLK);
    #1 ARESETn = 1'b1;
    tick();
    for (int i = 0; i < plans.size(); i++)
      run_burst(plans[i], (i + 1 < plans.size()), plans[(i + 1 < plans.size()) ? i + 1 : i]);

    // Reset asserted after beat 1 of a 4-beat burst.
    repeat (2) tick();
    raise(mk(1, 0, 3, 0, 0, 0, 0, 0, 0), 1'b0);
    wait_grant();
    AWVALID = 1'b1; AWLEN = LW'(3); AWREADY = 1'b1;
    tick();
    AWVALID = 1'b0; AWREADY = 1'b0; AWVALID_M0 = 1'b0;
    WVALID = 1'b1; WREADY = 1'b1; WLAST = 1'b0;
    tick();
    tick();
    WVALID = 1'b0; WREADY = 1'b0;
    @(posedge ACLK);
    #2 ARESETn = 1'b0;
    sb_burst.delete();
    ptr = RST_PRIO;
    repeat (2) tick();
    ARESETn = 1'b1;
    tick();
    q1 = mk(0, 1, 1, 0, 0, 1, 0, 0, 0);
    q2 = mk(1, 1, 2, 0, 0, 0, 0, 0, 0);
    run_burst(q1, 1'b1, q2);
    run_burst(q2, 1'b0, q2);

    repeat (4) tick();
    done = 1'b1;
  end

endmodule

// File: doc/aw_wr_arbiter.md
Name: aw_wr_arbiter

Overview:
Write-path arbiter that sits directly upstream of the AW channel mux and drives its one-hot `gnt` select. It arbitrates between masters M0 and M1 with round-robin priority. It holds the address grant until the AW handshake completes, then holds a W-channel grant until the burst's last data beat. It also checks that the WLAST position matches the accepted AWLEN.

Parameters:
- RST_PRIO, default 0: master favoured on the first arbitration after reset (0 = M0, 1 = M1).

Ports:
- ACLK  in  1  clock
- ARESETn  in  1  asynchronous active-low reset
- AWVALID_M0  in  1  address request from M0
- AWVALID_M1  in  1  address request from M1
- AWVALID  in  1  AWVALID at the mux output (granted master)
- AWREADY  in  1  AWREADY from the slave side
- AWLEN  in  `AXI_LEN_BITS  AWLEN at the mux output
- WVALID  in  1  WVALID of the W-granted master
- WREADY  in  1  WREADY from the slave side
- WLAST  in  1  WLAST of the W-granted master
- gnt  out  2  AW mux select: 2'b01 = M0, 2'b10 = M1, 2'b00 = none
- w_gnt  out  2  W mux select, same encoding
- busy  out  1  high whenever the state is not IDLE
- wlast_err  out  1  one-cycle pulse on a WLAST/length mismatch

Behaviour:
- All outputs are registered.
- Reset (asynchronous, ARESETn low):
  - state = IDLE; gnt = 00; w_gnt = 00; busy = 0; wlast_err = 0.
  - Beat counter = 0; captured length = 0.
  - Priority pointer = RST_PRIO.
  - Reset asserted mid-burst aborts immediately. There is no replay after reset release.
- States: IDLE -> ADDR -> DATA -> IDLE.
- IDLE:
  - gnt = 00 and w_gnt = 00.
  - If AWVALID_M0 or AWVALID_M1 is sampled high, go to ADDR on that edge and register gnt for the winner.
  - Winner selection:
    - If only one master requests, it wins.
    - If both request, the master indicated by the priority pointer wins.
    - The pointer then flips to the other master (it is updated only on a grant).
  - Grant latency: gnt is visible 1 cycle after the request is sampled.
- ADDR:
  - gnt is held stable.
  - On an edge with AWVALID && AWREADY: capture AWLEN, clear the beat counter, and go to DATA.
  - On the same edge, gnt goes to 00 and w_gnt is set to the granted master's code.
  - gnt never changes in ADDR before the handshake, even if the other master requests.
- DATA:
  - gnt = 00, so a new AW from either master is blocked; w_gnt is held.
  - Each edge with WVALID && WREADY is a beat.
  - Normal end: beat with counter == captured len and WLAST = 1. Go to IDLE, w_gnt = 00, no error.
  - Early WLAST: beat with WLAST = 1 and counter < len. Go to IDLE and pulse wlast_err.
  - Missing WLAST: beat with counter == len and WLAST = 0. Treat it as last, go to IDLE, and pulse wlast_err.
  - Otherwise, on a beat, the counter increments by 1. The counter is `AXI_LEN_BITS wide and never wraps, because the burst ends at len.
- No bypass: at least one IDLE cycle separates bursts, i.e. there is at least 1 bubble cycle between a WLAST beat and the next gnt.
- W before AW: W data offered before its AW is accepted sees w_gnt = 00 and is stalled. This is legal AXI, but this block serializes it.
- Simultaneous events:
  - A request arriving on the same edge as the DATA->IDLE transition is not granted that edge. It is granted on the next edge if still asserted.
- busy = 1 in ADDR and DATA.

Test Plan:
1. Reset, M0 only: AWVALID_M0 = 1 -> gnt = 01 next cycle. AWREADY after 2 cycles -> gnt = 00, w_gnt = 01. AWLEN = 3, beats 0..3 with WLAST on beat 3 -> w_gnt = 00 after beat 3, wlast_err never pulses.
2. Contention: both AWVALID held high for 3 back-to-back single-beat bursts (AWLEN = 0, RST_PRIO = 0) -> grant order M0, M1, M0, with exactly one IDLE cycle between each burst.
3. Early WLAST: AWLEN = 3, WLAST on beat 1 -> return to IDLE after beat 1, wlast_err high for exactly 1 cycle.
4. Missing WLAST: AWLEN = 2, WLAST = 0 on all beats -> burst ends after beat 2, wlast_err pulses once.
5. Stall hold: in ADDR with AWREADY = 0 for 5 cycles while the other master raises AWVALID -> gnt is unchanged. In DATA, WREADY = 0 stalls hold w_gnt and the counter.
6. Reset mid-DATA: ARESETn low after beat 1 of a 4-beat burst -> gnt, w_gnt, busy and wlast_err are 0 immediately (asynchronously). After release, M1 requesting alone is granted normally.
